// File: rtl/rom_loader_if.sv
// Byte-stream input, memory write port and load control/status for rom_loader.
// Stream rule: a byte moves on every rising edge where s_valid && s_ready; the
// source must hold s_data and s_valid stable until that edge.
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d;
  logic                  we;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output start, base_addr, word_count, s_data, s_valid,
    input  s_ready, a, d, we, busy, done, checksum
  );

  modport slave (
    input  start, base_addr, word_count, s_data, s_valid,
    output s_ready, a, d, we, busy, done, checksum
  );
endinterface

// File: rtl/rom_loader.sv
// Packs an MSB-first byte stream into DATA_WIDTH-bit words and writes them to
// consecutive addresses from a captured base, keeping a running word checksum.
module rom_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  rom_loader_if.slave bus,
  output logic [1:0]  state_dbg
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, a_q;
  logic [ADDR_WIDTH:0]   wc_q, idx_q;
  logic [BCW-1:0]        bcnt_q;
  logic [DATA_WIDTH-1:0] word_q, d_q, sum_q, word_next;
  logic                  accept, last_byte;

  assign accept    = (state_q == LOAD) && bus.s_valid;
  assign last_byte = (bcnt_q == BCW'(BYTES - 1));
  // New byte enters at the LSB end, so the first byte of a word finishes in the MSBs.
  assign word_next = DATA_WIDTH'({word_q, bus.s_data});

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.word_count == '0) ? DONE : LOAD;
      LOAD:    if (accept && last_byte) state_d = WRITE;
      WRITE:   state_d = (idx_q + 1'b1 == wc_q) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decode the registered state, so they change only on clock edges.
  always_comb begin
    bus.s_ready  = (state_q == LOAD);
    bus.we       = (state_q == WRITE);
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    bus.a        = a_q;
    bus.d        = d_q;
    bus.checksum = sum_q;
    state_dbg    = state_q;
  end

  // a/d are loaded with the last byte so they are already valid in the WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      wc_q   <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      a_q    <= '0;
      d_q    <= '0;
      sum_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            base_q <= bus.base_addr;
            wc_q   <= bus.word_count;
            idx_q  <= '0;
            bcnt_q <= '0;
            sum_q  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            word_q <= word_next;
            if (last_byte) begin
              d_q    <= word_next;
              a_q    <= base_q + idx_q[ADDR_WIDTH-1:0];
              bcnt_q <= '0;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          sum_q  <= sum_q + d_q;
          idx_q  <= idx_q + 1'b1;
          bcnt_q <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
